pwm_peripheral: RTL and testbench
=================================

// Module: pwm_peripheral
// PURPOSE
//   Consumer of the SPI register file: turns the five control bytes written over SPI into 16
//   registered output pins. Each pin is forced low, held high, or driven by one shared 8-bit PWM
//   waveform. Sits directly downstream of the SPI slave and directly drives the top-level uo_out/uio_out.
// PARAMETERS
//   CLK_DIV   13   clk cycles per PWM counter tick (10 MHz/(13*256) ~= 3.0 kHz period); legal >= 1
//   CNT_W     8    PWM counter / duty width; fixed at 8 for this design
// PORTS
//   clk               in   1   system clock
//   rst_n             in   1   reset, active-low, synchronous
//   en_reg_out_7_0    in   8   output enable, pins 7:0
//   en_reg_out_15_8   in   8   output enable, pins 15:8
//   en_reg_pwm_7_0    in   8   PWM mode select, pins 7:0 (1 = PWM, 0 = static high)
//   en_reg_pwm_15_8   in   8   PWM mode select, pins 15:8
//   pwm_duty_cycle    in   8   duty: high for duty/256 of the period; 0xFF = 100 %
//   pwm_out           out  16  pin drive; [7:0] -> uo_out, [15:8] -> uio_out
//   period_start      out  1   one-clk pulse on the first clk of every PWM period
// BEHAVIOUR
//   Reset (rst_n low at a clk edge): prescaler = 0, counter = 0, duty_active = 0, pwm_out = 16'h0000,
//     period_start = 0. Reset mid-period aborts the period; counting restarts from 0 once rst_n is high.
//   Prescaler: counts 0..CLK_DIV-1, wraps to 0; tick = (prescaler == CLK_DIV-1).
//   Counter: advances by 1 on tick; 8-bit natural wrap 255 -> 0 (no saturation). Period = 256*CLK_DIV clk.
//   period_start: registered; asserted for exactly one clk when counter wraps 255 -> 0
//     (and not during or for the first cycle after reset).
//   PWM level: pwm_level = (duty_active == 8'hFF) ? 1 : (counter < duty_active) (unsigned 8-bit compare).
//     duty 0x00 -> constantly low; 0x80 -> 128 of 256 counts high; 0xFF -> constantly high (special case).
//   Per pin i (0..15), with en_out/en_pwm = concatenation {15_8, 7_0}:
//     en_out[i] = 0               -> pwm_out[i] = 0
//     en_out[i] = 1, en_pwm[i] = 0 -> pwm_out[i] = 1
//     en_out[i] = 1, en_pwm[i] = 1 -> pwm_out[i] = pwm_level
//   Latency: pwm_out registered; reflects enable/mode changes and counter state 1 clk later. No handshake:
//     the input registers are quasi-static, written in the same clk domain by the SPI stage.
//   Simultaneous: a duty write landing on the wrap cycle is handled per CONFIGURATION; enable and mode
//     changes are never deferred.
// CONFIGURATION
//   PWM_SHADOW_EN defined: duty_active is a shadow register loaded from pwm_duty_cycle only on the
//     clk where the counter wraps 255 -> 0 (and at reset, to 0). Duty changes never create runt pulses;
//     a write landing on the wrap clk takes effect that period, later writes take effect at the next period.
//   PWM_SHADOW_EN undefined: duty_active = pwm_duty_cycle directly; new duty takes effect 1 clk later and
//     may truncate or extend the current high phase.
// STRUCTURE
//   pwm_pkg: PWM_CNT_W = 8, PWM_NUM_PINS = 16, PWM_DUTY_FULL = 8'hFF, default CLK_DIV constant.
//   Sub-module pwm_timebase: prescaler + counter + tick/period_start generation (clk, rst_n, counter, wrap).
//   Top level: duty shadow (optional), compare, 16-way pin mux, output registers.
// TESTING
//   rst_n low 3 clk mid-period with all enables set -> pwm_out = 0, period_start = 0; counter restarts at 0 after release.
//   en_out = 16'hFFFF, en_pwm = 0 -> pwm_out = 16'hFFFF one clk later; en_out = 0 -> 16'h0000.
//   en_out = en_pwm = 16'h0001, duty 0x80, CLK_DIV = 13 -> pin 0 high 1664 clk, low 1664 clk, period 3328 clk.
//   duty 0x00 -> pin held low for 3 full periods; duty 0xFF -> pin held high for 3 full periods.
//   PWM_SHADOW_EN: duty 0x40 -> 0xC0 written at counter 0x20 -> current period keeps 0x40 high time (832 clk),
//     next period 2496 clk high; without macro, high phase extends immediately to counter 0xC0.
//   period_start pulses exactly once per 3328 clk; mixed mask en_out = 16'hF0F0, en_pwm = 16'h3030 ->
//     pins 15:14, 7:6 static high, 13:12, 5:4 PWM, rest low.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared constants and types for the PWM output peripheral.
//   PWM_CNT_W           counter / duty width (fixed at 8)
//   PWM_NUM_PINS        number of driven output pins
//   PWM_DUTY_FULL       duty code that forces a constant-high waveform
//   PWM_CLK_DIV_DEFAULT clk cycles per PWM counter tick
//   pin_mode_e/pin_mode decode of the per-pin enable and mode bits
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int                   PWM_CNT_W           = 8;
  localparam int                   PWM_NUM_PINS        = 16;
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL       = 8'hFF;
  localparam int                   PWM_CLK_DIV_DEFAULT = 13;

  typedef enum logic [1:0] {
    PIN_OFF  = 2'd0,  // forced low
    PIN_HIGH = 2'd1,  // static high
    PIN_PWM  = 2'd2   // follows the shared PWM waveform
  } pin_mode_e;

  function automatic pin_mode_e pin_mode(input logic en_out, input logic en_pwm);
    if (!en_out)     return PIN_OFF;
    else if (en_pwm) return PIN_PWM;
    else             return PIN_HIGH;
  endfunction

endpackage

// File: rtl/pwm_if.sv
// -----------------------------------------------------------------------------
// pwm_if
//   Register-side and pin-side signals of the PWM peripheral.
//   master : register file side (drives enables/mode/duty, observes outputs)
//   slave  : PWM peripheral side
//   en_reg_out_7_0/15_8  output enables, pins 7:0 / 15:8
//   en_reg_pwm_7_0/15_8  PWM mode select (1 = PWM, 0 = static high)
//   pwm_duty_cycle       duty code, high for duty/256 of the period
//   pwm_out              registered pin drive ([7:0] uo_out, [15:8] uio_out)
//   period_start         one-clk pulse on the first clk of every PWM period
// -----------------------------------------------------------------------------
interface pwm_if;
  import pwm_pkg::*;

  logic [7:0]              en_reg_out_7_0;
  logic [7:0]              en_reg_out_15_8;
  logic [7:0]              en_reg_pwm_7_0;
  logic [7:0]              en_reg_pwm_15_8;
  logic [PWM_CNT_W-1:0]    pwm_duty_cycle;
  logic [PWM_NUM_PINS-1:0] pwm_out;
  logic                    period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    input  pwm_out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8,
           pwm_duty_cycle,
    output pwm_out, period_start
  );

endinterface

// File: rtl/pwm_timebase.sv
// -----------------------------------------------------------------------------
// pwm_timebase
//   Prescaler plus 8-bit PWM counter. The counter advances once every CLK_DIV
//   clk cycles and wraps 255 -> 0, so one PWM period is 256*CLK_DIV clk.
//   clk          system clock
//   rst_n        synchronous active-low reset
//   counter      current PWM counter value
//   wrap         combinational, high on the clk whose edge takes 255 -> 0
//   period_start registered copy of wrap: high on the first clk of a period
// -----------------------------------------------------------------------------
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_CNT_W-1:0] counter,
  output logic                 wrap,
  output logic                 period_start
);

  // A divider of 1 still needs a one-bit prescaler that simply stays at 0.
  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [PRE_W-1:0] prescaler;
  logic             tick;

  assign tick = (prescaler == PRE_W'(CLK_DIV - 1));
  assign wrap = tick && (counter == {PWM_CNT_W{1'b1}});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours; reset is synchronous, tested
  // inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler    <= '0;
      counter      <= '0;
      period_start <= 1'b0;
    end else begin
      prescaler    <= tick ? '0 : prescaler + PRE_W'(1);
      // Natural 8-bit wrap 255 -> 0, no saturation.
      if (tick) counter <= counter + PWM_CNT_W'(1);
      period_start <= wrap;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//   Turns the SPI-written enable/mode/duty bytes into 16 registered output
//   pins. Each pin is forced low, held high, or follows one shared 8-bit PWM
//   waveform; duty 0xFF is a special case meaning constant high.
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    pwm_if.slave: register inputs, pwm_out and period_start
//   Optional build macro: PWM_SHADOW_EN -- the duty is captured into a shadow
//   register only at the period wrap, so duty changes never produce runt
//   pulses. Without it the duty input is used directly.
// -----------------------------------------------------------------------------
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_n,
  pwm_if.slave   bus
);

  logic [PWM_CNT_W-1:0]    counter;
  logic                    wrap;
  logic [PWM_CNT_W-1:0]    duty_active;
  logic                    pwm_level;
  logic [PWM_NUM_PINS-1:0] en_out;
  logic [PWM_NUM_PINS-1:0] en_pwm;
  logic [PWM_NUM_PINS-1:0] pin_next;

  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .counter      (counter),
    .wrap         (wrap),
    .period_start (bus.period_start)
  );

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

`ifdef PWM_SHADOW_EN
  // Loaded on the same edge that takes the counter to 0, so a write present
  // on the wrap clk governs the period that is just starting.
  always_ff @(posedge clk) begin
    if (!rst_n)    duty_active <= '0;
    else if (wrap) duty_active <= bus.pwm_duty_cycle;
  end
`else
  assign duty_active = bus.pwm_duty_cycle;
`endif

  // 0xFF would otherwise leave the pin low for count 255; treat it as 100 %.
  assign pwm_level = (duty_active == PWM_DUTY_FULL) ? 1'b1 : (counter < duty_active);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    pin_next = '0;
    for (int i = 0; i < PWM_NUM_PINS; i++) begin
      case (pin_mode(en_out[i], en_pwm[i]))
        PIN_HIGH: pin_next[i] = 1'b1;
        PIN_PWM:  pin_next[i] = pwm_level;
        default:  pin_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) bus.pwm_out <= '0;
    else        bus.pwm_out <= pin_next;
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//   Self-checking bench for pwm_peripheral (CLK_DIV = 13). Expected run
//   lengths and intervals are pushed to a queue when a scenario is set up and
//   popped when the corresponding measurement completes. Expectations for the
//   duty-change scenario follow the PWM_SHADOW_EN build macro.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;
  import pwm_pkg::*;

  localparam int CLK_DIV = 13;
  localparam int PERIOD  = 256 * CLK_DIV;  // 3328 clk
  localparam int HALF    = 128 * CLK_DIV;  // 1664 clk

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  pwm_if bus_if ();

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic set_regs(input logic [15:0] en_out, input logic [15:0] en_pwm,
                          input logic [7:0] duty);
    bus_if.en_reg_out_7_0  = en_out[7:0];
    bus_if.en_reg_out_15_8 = en_out[15:8];
    bus_if.en_reg_pwm_7_0  = en_pwm[7:0];
    bus_if.en_reg_pwm_15_8 = en_pwm[15:8];
    bus_if.pwm_duty_cycle  = duty;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advances to the negedge where period_start is seen high; a missing pulse
  // is counted as a failed comparison.
  task automatic wait_period_start(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < PERIOD + 16; i++) begin
      @(negedge clk);
      if (bus_if.period_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: period_start not seen within %0d clk", name, PERIOD + 16);
    end
  endtask

  // Counts consecutive negedge samples (starting with the current one) where
  // pin 0 equals level; returns at the first sample that differs.
  task automatic measure_run(input logic level, output int n);
    n = 0;
    while (bus_if.pwm_out[0] === level && n < 2 * PERIOD) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Number of clk from the current negedge to the next period_start sample.
  task automatic measure_interval(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.period_start !== 1'b1 && n < 2 * PERIOD);
  endtask

  task automatic test_reset();
    int n;
    int exp;
    set_regs(16'hFFFF, 16'h0000, 8'h80);
    step(1000);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if (bus_if.pwm_out !== 16'h0000) begin
        errors++;
        $display("FAIL reset_pwm_out[%0d]: got %h want 0000", i, bus_if.pwm_out);
      end
      checks++;
      if (bus_if.period_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_period_start[%0d]: got %b want 0", i, bus_if.period_start);
      end
    end
    rst_n = 1'b1;
    exp_q.push_back(PERIOD);
    step(1);
    checks++;
    if (bus_if.pwm_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL post_reset_static: got %h want ffff", bus_if.pwm_out);
    end
    // Counter restarts at 0: the first wrap is a full period after release.
    n = 1;
    while (bus_if.period_start !== 1'b1 && n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (n !== exp) begin
      errors++;
      $display("FAIL reset_first_period: got %0d clk want %0d", n, exp);
    end
  endtask

  task automatic test_static();
    set_regs(16'hFFFF, 16'h0000, 8'h80);
    step(1);
    checks++;
    if (bus_if.pwm_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL static_all_high: got %h want ffff", bus_if.pwm_out);
    end
    set_regs(16'h0000, 16'h0000, 8'h80);
    step(1);
    checks++;
    if (bus_if.pwm_out !== 16'h0000) begin
      errors++;
      $display("FAIL static_all_off: got %h want 0000", bus_if.pwm_out);
    end
    set_regs(16'h5A5A, 16'h0000, 8'h80);
    step(1);
    checks++;
    if (bus_if.pwm_out !== 16'h5A5A) begin
      errors++;
      $display("FAIL static_pattern: got %h want 5a5a", bus_if.pwm_out);
    end
  endtask

  task automatic test_duty_half();
    int hi;
    int lo;
    int exp;
    set_regs(16'h0001, 16'h0001, 8'h80);
    wait_period_start("duty_half_sync");
    exp_q.push_back(HALF);
    exp_q.push_back(HALF);
    step(1);
    measure_run(1'b1, hi);
    exp = exp_q.pop_front();
    checks++;
    if (hi !== exp) begin
      errors++;
      $display("FAIL duty80_high: got %0d clk want %0d", hi, exp);
    end
    checks++;
    if (bus_if.pwm_out[15:1] !== 15'h0000) begin
      errors++;
      $display("FAIL duty80_other_pins: got %h want 0000", bus_if.pwm_out[15:1]);
    end
    measure_run(1'b0, lo);
    exp = exp_q.pop_front();
    checks++;
    if (lo !== exp) begin
      errors++;
      $display("FAIL duty80_low: got %0d clk want %0d", lo, exp);
    end
  endtask

  task automatic test_period_start();
    int n;
    int exp;
    wait_period_start("period_start_sync");
    step(1);
    checks++;
    if (bus_if.period_start !== 1'b0) begin
      errors++;
      $display("FAIL period_start_width: still %b one clk later, want 0", bus_if.period_start);
    end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(PERIOD);
      measure_interval(n);
      exp = exp_q.pop_front();
      checks++;
      // One clk was already consumed by the width check above on the first pass.
      if (n + ((k == 0) ? 1 : 0) !== exp) begin
        errors++;
        $display("FAIL period_start_interval[%0d]: got %0d clk want %0d",
                 k, n + ((k == 0) ? 1 : 0), exp);
      end
    end
  endtask

  task automatic test_duty_extremes();
    int cnt;
    int exp;
    set_regs(16'h0001, 16'h0001, 8'h00);
    wait_period_start("duty00_sync");
    exp_q.push_back(0);
    cnt = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step(1);
      if (bus_if.pwm_out[0] === 1'b1) cnt++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (cnt !== exp) begin
      errors++;
      $display("FAIL duty00_high_samples: got %0d want %0d", cnt, exp);
    end
    set_regs(16'h0001, 16'h0001, 8'hFF);
    wait_period_start("dutyff_sync");
    exp_q.push_back(0);
    cnt = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step(1);
      if (bus_if.pwm_out[0] !== 1'b1) cnt++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (cnt !== exp) begin
      errors++;
      $display("FAIL dutyff_low_samples: got %0d want %0d", cnt, exp);
    end
  endtask

  task automatic test_shadow();
    int hi;
    int exp;
    int t;
    set_regs(16'h0001, 16'h0001, 8'h40);
    wait_period_start("shadow_sync0");
`ifdef PWM_SHADOW_EN
    exp_q.push_back(64 * CLK_DIV);   // current period keeps the 0x40 high time
`else
    exp_q.push_back(192 * CLK_DIV);  // high phase stretches to counter 0xC0
`endif
    exp_q.push_back(192 * CLK_DIV);
    step(1);
    // t counts clk since period_start; counter is 0x20 at t = 416..428.
    hi = 0;
    t  = 1;
    while (bus_if.pwm_out[0] === 1'b1 && hi < 2 * PERIOD) begin
      hi++;
      if (t == 420) bus_if.pwm_duty_cycle = 8'hC0;
      @(negedge clk);
      t++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (hi !== exp) begin
      errors++;
      $display("FAIL duty_change_current_high: got %0d clk want %0d", hi, exp);
    end
    wait_period_start("shadow_sync1");
    step(1);
    measure_run(1'b1, hi);
    exp = exp_q.pop_front();
    checks++;
    if (hi !== exp) begin
      errors++;
      $display("FAIL duty_change_next_high: got %0d clk want %0d", hi, exp);
    end
  endtask

  task automatic test_mixed();
    set_regs(16'hF0F0, 16'h3030, 8'h80);
    wait_period_start("mixed_sync");
    step(1);
    checks++;
    if (bus_if.pwm_out !== 16'hF0F0) begin
      errors++;
      $display("FAIL mixed_pwm_high_phase: got %h want f0f0", bus_if.pwm_out);
    end
    step(1699);
    checks++;
    if (bus_if.pwm_out !== 16'hC0C0) begin
      errors++;
      $display("FAIL mixed_pwm_low_phase: got %h want c0c0", bus_if.pwm_out);
    end
  endtask

  initial begin
    set_regs(16'h0000, 16'h0000, 8'h00);
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    test_reset();
    test_static();
    test_duty_half();
    test_period_start();
    test_duty_extremes();
    test_shadow();
    test_mixed();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
